// File: rtl/playfield_bg_draw_if.sv
// Pixel-stream and border-flash handshake bundle between the VGA timing path and playfield_bg_draw.
// master drives pixel coordinates, frame strobe and flash requests; slave returns colour and status.
interface playfield_bg_draw_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        flashReq;
  logic [3:0]  flashCount;
  logic [7:0]  BG_RGB;
  logic        insidePlayfield;
  logic        flashBusy;

  modport master (
    output pixelX, pixelY, startOfFrame, flashReq, flashCount,
    input  BG_RGB, insidePlayfield, flashBusy
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, flashReq, flashCount,
    output BG_RGB, insidePlayfield, flashBusy
  );
endinterface

// File: rtl/playfield_bg_draw.sv
// Framed playfield background painter with a frame-synchronous border-flash sequencer; 1 clk pixel latency.
// Optional macro GRID_LINES_EN paints a tile grid over the inner fill.
module playfield_bg_draw #(
  parameter int          ORIGIN_X     = 16,
  parameter int          ORIGIN_Y     = 16,
  parameter int          FIELD_W      = 544,
  parameter int          FIELD_H      = 448,
  parameter logic [7:0]  OUTER_RGB    = 8'hFC,
  parameter logic [7:0]  BORDER_RGB   = 8'hFF,
  parameter logic [7:0]  FLASH_RGB    = 8'hE0,
  parameter logic [7:0]  INNER_RGB    = 8'hAF,
`ifdef GRID_LINES_EN
  parameter int          TILE_LOG2    = 4,
  parameter logic [7:0]  GRID_RGB     = 8'h6E,
`endif
  parameter int          BLINK_FRAMES = 8
) (
  input logic              clk,
  input logic              reset,
  playfield_bg_draw_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  localparam int             FCW     = $clog2(BLINK_FRAMES + 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

  localparam logic [10:0] X_L = 11'(ORIGIN_X);
  localparam logic [10:0] X_R = 11'(ORIGIN_X + FIELD_W);
  localparam logic [10:0] Y_T = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_B = 11'(ORIGIN_Y + FIELD_H);

  logic [1:0]     state_q, state_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]     remaining_q, remaining_d;
  logic           flash_busy_q, flash_busy_d;
  logic [7:0]     bg_rgb_q, bg_rgb_d;
  logic           inside_q, inside_d;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    remaining_d  = remaining_q;
    flash_busy_d = flash_busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.flashReq && (bus.flashCount != 4'd0)) begin
          state_d      = ST_ON;
          remaining_d  = bus.flashCount;
          frame_cnt_d  = '0;
          flash_busy_d = 1'b1;
        end
      end
      ST_ON, ST_OFF: begin
        if (bus.startOfFrame) begin
          if (frame_cnt_q == FC_LAST) begin
            frame_cnt_d = '0;
            if (state_q == ST_ON) begin
              state_d = ST_OFF;
            end else if (remaining_q > 4'd1) begin
              state_d     = ST_ON;
              remaining_d = remaining_q - 4'd1;
            end else begin
              state_d      = ST_IDLE;
              remaining_d  = 4'd0;
              flash_busy_d = 1'b0;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
          end
        end
      end
      default: begin
        state_d      = ST_IDLE;
        frame_cnt_d  = '0;
        remaining_d  = 4'd0;
        flash_busy_d = 1'b0;
      end
    endcase
  end

  logic on_col, on_row, border_px, inside_px, grid_px;
  logic [7:0] border_rgb;

  always_comb begin
    on_col    = ((bus.pixelX == X_L) || (bus.pixelX == X_R)) &&
                (bus.pixelY >= Y_T) && (bus.pixelY <= Y_B);
    on_row    = ((bus.pixelY == Y_T) || (bus.pixelY == Y_B)) &&
                (bus.pixelX >= X_L) && (bus.pixelX <= X_R);
    border_px = on_col || on_row;
    inside_px = (bus.pixelX > X_L) && (bus.pixelX < X_R) &&
                (bus.pixelY > Y_T) && (bus.pixelY < Y_B);
    // Next-state colour, so a flash accepted mid-frame shows on the same edge flashBusy rises.
    border_rgb = (state_d == ST_ON) ? FLASH_RGB : BORDER_RGB;
  end

`ifdef GRID_LINES_EN
  logic [TILE_LOG2-1:0] dx_lo, dy_lo;
  always_comb begin
    dx_lo   = bus.pixelX[TILE_LOG2-1:0] - X_L[TILE_LOG2-1:0];
    dy_lo   = bus.pixelY[TILE_LOG2-1:0] - Y_T[TILE_LOG2-1:0];
    grid_px = inside_px && ((dx_lo == '0) || (dy_lo == '0));
  end
`else
  assign grid_px = 1'b0;
`endif

  always_comb begin
    bg_rgb_d = OUTER_RGB;
    inside_d = inside_px;
    if (border_px) begin
      bg_rgb_d = border_rgb;
`ifdef GRID_LINES_EN
    end else if (grid_px) begin
      bg_rgb_d = GRID_RGB;
`endif
    end else if (inside_px && !grid_px) begin
      bg_rgb_d = INNER_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      remaining_q  <= 4'd0;
      flash_busy_q <= 1'b0;
      bg_rgb_q     <= OUTER_RGB;
      inside_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      remaining_q  <= remaining_d;
      flash_busy_q <= flash_busy_d;
      bg_rgb_q     <= bg_rgb_d;
      inside_q     <= inside_d;
    end
  end

  assign bus.BG_RGB          = bg_rgb_q;
  assign bus.insidePlayfield = inside_q;
  assign bus.flashBusy       = flash_busy_q;

endmodule
